// File: rtl/elbeth_exs_muldiv_pkg.sv
// Shared types and constants for the EXS-stage iterative RV32M multiply/divide unit.
// Holds the M-op funct3 encodings, FSM state encoding, iteration count, the
// latched-operation context payload, and operand signedness helpers.
package elbeth_exs_muldiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ACC_W     = 2 * XLEN;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned NUM_STEPS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Everything about the in-flight op that is decided once at latch time.
  typedef struct packed {
    m_op_e             op;
    logic              neg;   // negate the selected result at completion
    logic              div0;  // divisor was zero
    logic              ovf;   // signed 0x80000000 / -1
    logic [XLEN-1:0]   rs1;   // raw dividend, returned by REM(U) on divide-by-zero
    logic [XLEN-1:0]   opnd;  // multiplicand or divisor magnitude
  } op_ctx_t;

  function automatic logic rs1_signed(input m_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input m_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/elbeth_muldiv_step.sv
// One unsigned iteration of the multiply/divide datapath (combinational).
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : 64-bit accumulator; mul {hi partial, multiplier}, div {remainder, quotient}
//   opnd_i   : multiplicand (mul) or divisor (div) magnitude
//   acc_o    : accumulator after this step
module elbeth_muldiv_step
  import elbeth_exs_muldiv_pkg::*;
(
  input  logic             is_div_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [XLEN-1:0]  opnd_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            take;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB is set,
    // then shift the whole accumulator right, keeping the carry.
    add_sum = {1'b0, acc_i[ACC_W-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: shift {rem, quo} left; subtract the divisor if it fits.
    rem_sh  = acc_i[ACC_W-1:XLEN-1];
    take    = rem_sh >= {1'b0, opnd_i};
    rem_sub = XLEN'(rem_sh - {1'b0, opnd_i});
    if (is_div_i) begin
      acc_o = {(take ? rem_sub : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], take};
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/elbeth_exs_muldiv.sv
// Iterative RV32M multiply/divide unit in the EXS stage.
// Fixed 33-cycle stall per op (latch cycle + 32 iterations), then a one-cycle done pulse.
//   clk, rst (sync, active-low), ctrl_flush (sync abort)
//   exs_muldiv_req, exs_funct3, exs_rs1_data, exs_rs2_data : op from ID/EXS register
//   muldiv_stall  : combinational stall request
//   muldiv_done   : one-cycle pulse, result valid
//   muldiv_result : result, held until next done or reset/flush
module elbeth_exs_muldiv
  import elbeth_exs_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_flush,
  input  logic            exs_muldiv_req,
  input  logic [2:0]      exs_funct3,
  input  logic [XLEN-1:0] exs_rs1_data,
  input  logic [XLEN-1:0] exs_rs2_data,
  output logic            muldiv_stall,
  output logic            muldiv_done,
  output logic [XLEN-1:0] muldiv_result
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  op_ctx_t          ctx_q, ctx_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;

  m_op_e            req_op;
  logic             sa, sb;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [ACC_W-1:0] step_acc;
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  quo_mag, rem_mag, quo, rem, fix_result;

  // Operand conditioning for the incoming request.
  always_comb begin
    req_op = m_op_e'(exs_funct3);
    sa     = rs1_signed(req_op) & exs_rs1_data[XLEN-1];
    sb     = rs2_signed(req_op) & exs_rs2_data[XLEN-1];
    mag_a  = sa ? XLEN'(-exs_rs1_data) : exs_rs1_data;
    mag_b  = sb ? XLEN'(-exs_rs2_data) : exs_rs2_data;
  end

  elbeth_muldiv_step u_step (
    .is_div_i (ctx_q.op[2]),
    .acc_i    (acc_q),
    .opnd_i   (ctx_q.opnd),
    .acc_o    (step_acc)
  );

  // Sign and special-case fix-up applied to the final iteration's output.
  always_comb begin
    prod    = ctx_q.neg ? ACC_W'(-step_acc) : step_acc;
    quo_mag = step_acc[XLEN-1:0];
    rem_mag = step_acc[ACC_W-1:XLEN];
    quo     = ctx_q.neg ? XLEN'(-quo_mag) : quo_mag;
    rem     = ctx_q.neg ? XLEN'(-rem_mag) : rem_mag;
    case (ctx_q.op)
      OP_MUL:               fix_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:             fix_result = prod[ACC_W-1:XLEN];
      OP_DIV, OP_DIVU:      fix_result = ctx_q.div0 ? '1 :
                                         ctx_q.ovf  ? {1'b1, {(XLEN-1){1'b0}}} : quo;
      OP_REM, OP_REMU:      fix_result = ctx_q.div0 ? ctx_q.rs1 :
                                         ctx_q.ovf  ? '0 : rem;
      default:              fix_result = '0;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ctx_d    = ctx_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (exs_muldiv_req) begin
          state_d    = S_BUSY;
          cnt_d      = '0;
          ctx_d.op   = req_op;
          ctx_d.neg  = (req_op == OP_REM || req_op == OP_REMU) ? sa : (sa ^ sb);
          ctx_d.div0 = (exs_rs2_data == '0);
          ctx_d.ovf  = (req_op == OP_DIV || req_op == OP_REM) &&
                       (exs_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (exs_rs2_data == '1);
          ctx_d.rs1  = exs_rs1_data;
          // Divide iterates on the dividend, multiply on the multiplier.
          ctx_d.opnd = req_op[2] ? mag_b : mag_a;
          acc_d      = {{XLEN{1'b0}}, (req_op[2] ? mag_a : mag_b)};
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_STEPS - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = fix_result;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ctrl_flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      ctx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ctx_q    <= ctx_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign muldiv_stall  = rst & exs_muldiv_req & (state_q != S_DONE);
  assign muldiv_done   = done_q;
  assign muldiv_result = result_q;

endmodule
